// File: rtl/sccb_target.sv
// Purpose:      SCCB target (camera-side responder) with an internal 8-bit register file.
// Latency:      ACK/read bits driven 1 sccb_clk after the filtered SIO_C falling edge;
//               reg_wr pulses 1 sccb_clk after the 8th data-bit rising edge.
// Backpressure: none; the bus master owns all timing and SIO_C is never stretched.
// Ports:
//   sccb_clk, sccb_reset      sole clock, synchronous active-high reset
//   pwdn                      1 = ignore bus, release SIO_D, hold FSM in IDLE
//   sio_c_in, sio_d_in        raw (asynchronous) pad inputs
//   sio_d_oe                  1 = pull SIO_D low
//   reg_wr/reg_waddr/reg_wdata  one-cycle register-write report
//   busy                      START seen, STOP not yet seen
//   nack_cnt                  saturating count of ID mismatches
module sccb_target #(
  parameter logic [6:0] DEV_ID   = 7'h21,
  parameter int         NUM_REGS = 256,
  parameter int         FILT_LEN = 3
) (
  input  logic       sccb_clk,
  input  logic       sccb_reset,
  input  logic       pwdn,
  input  logic       sio_c_in,
  input  logic       sio_d_in,
  output logic       sio_d_oe,
  output logic       reg_wr,
  output logic [7:0] reg_waddr,
  output logic [7:0] reg_wdata,
  output logic       busy,
  output logic [7:0] nack_cnt
);

  localparam int          AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int          CW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned NREG_U = NUM_REGS;

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WD_ACK, RD, RD_NA, SKIP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning. Index 0 is SIO_C, index 1 is SIO_D. Both lines idle
  // high, so the pipeline resets to 1 to avoid a phantom edge after reset.
  // A filtered line only follows its synced input once the new value has
  // been seen for FILT_LEN consecutive cycles.
  // ---------------------------------------------------------------------------
  logic [1:0]    sync1, sync2, filt, filt_q;
  logic [CW-1:0] fcnt [2];

  always_ff @(posedge sccb_clk) begin
    if (sccb_reset) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= {sio_d_in, sio_c_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + CW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise =  filt[0] & ~filt_q[0];
  assign scl_fall = ~filt[0] &  filt_q[0];
  assign sda_rise =  filt[1] & ~filt_q[1];
  assign sda_fall = ~filt[1] &  filt_q[1];
  assign start    = sda_fall & scl_f;
  assign stop     = sda_rise & scl_f;

  // ---------------------------------------------------------------------------
  // Register file. Its only write source is the registered reg_wr report,
  // so storage updates one cycle after the pulse is visible on the ports.
  // ---------------------------------------------------------------------------
  logic [7:0] regs [NUM_REGS];
  logic [7:0] ptr;
  logic       ptr_ok, waddr_ok;
  logic [7:0] rd_byte;

  assign ptr_ok   = 32'(ptr) < NREG_U;
  assign waddr_ok = 32'(reg_waddr) < NREG_U;
  assign rd_byte  = ptr_ok ? regs[ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge sccb_clk) begin
    if (sccb_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (reg_wr && waddr_ok) begin
      regs[reg_waddr[AW-1:0]] <= reg_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol FSM.
  // bit_cnt counts SIO_C rising edges within the current byte. Every ACK
  // state is entered with bit_cnt=8: the first falling edge there starts the
  // ACK drive, the 9th rise moves bit_cnt to 9, and the falling edge after
  // that ends the ACK slot.
  // ---------------------------------------------------------------------------
  state_t     state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shift, shift_nx, ptr_nx, in_byte;
  logic [7:0] waddr_nx, wdata_nx, nack_nx;
  logic       oe_nx, busy_nx, wr_nx;

  assign in_byte = {shift[6:0], sda_f};

  always_ff @(posedge sccb_clk) begin
    if (sccb_reset) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      ptr       <= 8'h00;
      sio_d_oe  <= 1'b0;
      busy      <= 1'b0;
      reg_wr    <= 1'b0;
      reg_waddr <= 8'h00;
      reg_wdata <= 8'h00;
      nack_cnt  <= 8'h00;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      ptr       <= ptr_nx;
      sio_d_oe  <= oe_nx;
      busy      <= busy_nx;
      reg_wr    <= wr_nx;
      reg_waddr <= waddr_nx;
      reg_wdata <= wdata_nx;
      nack_cnt  <= nack_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    ptr_nx     = ptr;
    oe_nx      = sio_d_oe;
    busy_nx    = busy;
    wr_nx      = 1'b0;
    waddr_nx   = reg_waddr;
    wdata_nx   = reg_wdata;
    nack_nx    = nack_cnt;

    if (pwdn) begin
      state_nx   = IDLE;
      bit_cnt_nx = 4'd0;
      oe_nx      = 1'b0;
      busy_nx    = 1'b0;
    end else if (start) begin
      // Also a repeated START: any partially received byte is dropped.
      state_nx   = ID;
      bit_cnt_nx = 4'd0;
      oe_nx      = 1'b0;
      busy_nx    = 1'b1;
    end else if (stop) begin
      state_nx   = IDLE;
      bit_cnt_nx = 4'd0;
      oe_nx      = 1'b0;
      busy_nx    = 1'b0;
    end else begin
      unique case (state)
        IDLE, SKIP: begin
          oe_nx = 1'b0;
        end

        ID, SUB, WDATA: begin
          if (scl_rise) begin
            shift_nx   = in_byte;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == ID) begin
                if (in_byte[7:1] == DEV_ID) begin
                  state_nx = ID_ACK;
                end else begin
                  state_nx = SKIP;
                  if (nack_cnt != 8'hFF) nack_nx = nack_cnt + 8'd1;
                end
              end else if (state == SUB) begin
                ptr_nx   = in_byte;
                state_nx = SUB_ACK;
              end else begin
                wr_nx    = 1'b1;
                waddr_nx = ptr;
                wdata_nx = in_byte;
                state_nx = WD_ACK;
              end
            end
          end
        end

        ID_ACK, SUB_ACK, WD_ACK: begin
          if (scl_rise) begin
            bit_cnt_nx = 4'd9;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              oe_nx = 1'b1;
            end else begin
              oe_nx      = 1'b0;
              bit_cnt_nx = 4'd0;
              if (state == ID_ACK) begin
                // shift still holds the ID byte; bit 0 is R/W.
                if (shift[0]) begin
                  state_nx = RD;
                  shift_nx = rd_byte;
                  oe_nx    = ~rd_byte[7];
                end else begin
                  state_nx = SUB;
                end
              end else if (state == SUB_ACK) begin
                state_nx = WDATA;
              end else begin
                state_nx = SKIP;
              end
            end
          end
        end

        RD: begin
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              oe_nx    = 1'b0;
              state_nx = RD_NA;
            end else begin
              // shift[6] is the next bit to present once the byte shifts.
              shift_nx = {shift[6:0], 1'b0};
              oe_nx    = ~shift[6];
            end
          end
        end

        RD_NA: begin
          // Master NA (1) or a tolerated ACK (0); either way the read ends.
          if (scl_rise) state_nx = SKIP;
        end

        default: begin
          state_nx = IDLE;
          oe_nx    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Purpose: randomized + directed bench for sccb_target acting as SCCB master,
//          compared against a register-array model of the camera target.
module tb_sccb_target;

  localparam int Q = 8;  // sccb_clk cycles per quarter SIO_C period

  logic       clk = 1'b0;
  logic       rst, pwdn, scl, sda_m, sda_bus;
  logic       oe, reg_wr, busy;
  logic [7:0] waddr, wdata, nack;

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull low.
  assign sda_bus = sda_m & ~oe;

  sccb_target dut (
    .sccb_clk  (clk),
    .sccb_reset(rst),
    .pwdn      (pwdn),
    .sio_c_in  (scl),
    .sio_d_in  (sda_bus),
    .sio_d_oe  (oe),
    .reg_wr    (reg_wr),
    .reg_waddr (waddr),
    .reg_wdata (wdata),
    .busy      (busy),
    .nack_cnt  (nack)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what a camera register block should hold.
  logic [7:0] mreg [256];
  logic [7:0] mptr;
  int         mnack;

  // Captured write reports and SCL-high output-change watcher.
  logic [15:0] wr_q[$];
  int          oe_hi_chg = 0;
  logic        oe_last = 1'b0;

  always @(negedge clk) begin
    if (reg_wr === 1'b1) wr_q.push_back({waddr, wdata});
    if (!rst && !pwdn && scl && (oe !== oe_last)) oe_hi_chg++;
    oe_last = oe;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not complete");
  end

  // --------------------------- bus primitives -----------------------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic rstart_c();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic clk_bit(input logic v, output logic line, output logic drv);
    sda_m = v;  wait_q();
    scl = 1'b1; wait_q();
    line = sda_bus;
    drv  = oe;
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic l, d;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], l, d);
    clk_bit(1'b1, l, d);
    ack = d;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic l, d;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, l, d);
      b[i] = l;
    end
    clk_bit(1'b1, l, d);  // master NA
  endtask

  // --------------------------- checked frames ------------------------------
  task automatic check_no_writes(input string tag);
    check_val(tag, 32'(wr_q.size()), 32'd0);
    wr_q.delete();
  endtask

  task automatic check_one_write(input logic [7:0] a, input logic [7:0] d);
    check_val("wr_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) begin
      check_val("wr_addr", 32'(wr_q[0][15:8]), 32'(a));
      check_val("wr_data", 32'(wr_q[0][7:0]), 32'(d));
    end
    wr_q.delete();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    logic k;
    start_c();
    check_val("busy_start", 32'(busy), 32'd1);
    send_byte(8'h42, k); check_val("wr_id_ack", 32'(k), 32'd1);
    send_byte(a, k);     check_val("wr_sub_ack", 32'(k), 32'd1);
    send_byte(d, k);     check_val("wr_dat_ack", 32'(k), 32'd1);
    stop_c();
    check_val("busy_stop", 32'(busy), 32'd0);
    mreg[a] = d;
    mptr    = a;
    check_one_write(a, d);
  endtask

  task automatic set_ptr(input logic [7:0] a);
    logic k;
    start_c();
    send_byte(8'h42, k); check_val("sp_id_ack", 32'(k), 32'd1);
    send_byte(a, k);     check_val("sp_sub_ack", 32'(k), 32'd1);
    stop_c();
    mptr = a;
    check_no_writes("sp_no_wr");
  endtask

  task automatic do_read();
    logic       k;
    logic [7:0] b;
    start_c();
    send_byte(8'h43, k); check_val("rd_id_ack", 32'(k), 32'd1);
    recv_byte(b);
    stop_c();
    check_val("rd_data", 32'(b), 32'(mreg[mptr]));
    check_val("rd_busy", 32'(busy), 32'd0);
    check_no_writes("rd_no_wr");
  endtask

  task automatic bad_id(input logic [7:0] id);
    logic k;
    start_c();
    send_byte(id, k); check_val("bad_id_ack", 32'(k), 32'd0);
    stop_c();
    if (mnack != 255) mnack++;
    check_val("nack_cnt", 32'(nack), 32'(mnack));
    check_no_writes("bad_no_wr");
  endtask

  function automatic logic [7:0] rand_bad_id();
    logic [7:0] id;
    do id = 8'($urandom); while (id[7:1] == 7'h21);
    return id;
  endfunction

  // ------------------------------- sequence --------------------------------
  initial begin
    logic       k, l, d;
    logic [7:0] a, v;

    rst = 1'b1; pwdn = 1'b0; scl = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
    mptr = 8'h00; mnack = 0;
    repeat (4) @(negedge clk);
    check_val("rst_oe", 32'(oe), 32'd0);
    check_val("rst_wr", 32'(reg_wr), 32'd0);
    check_val("rst_waddr", 32'(waddr), 32'd0);
    check_val("rst_wdata", 32'(wdata), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_nack", 32'(nack), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // 3-phase write then read back through the pointer it left behind.
    do_write(8'h12, 8'h80);
    do_read();

    // 2-phase write only moves the pointer; the read follows it.
    do_write(8'h0A, 8'($urandom));
    do_write(8'h33, 8'h5C);
    set_ptr(8'h0A);
    do_read();

    // Foreign ID is ignored and counted; the next valid frame still works.
    bad_id(8'h60);
    do_write(8'h07, 8'($urandom));

    // Repeated START 4 bits into a data byte: no write, new frame decoded.
    start_c();
    send_byte(8'h42, k); check_val("rs_id_ack", 32'(k), 32'd1);
    send_byte(8'h20, k); check_val("rs_sub_ack", 32'(k), 32'd1);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, l, d);
    rstart_c();
    check_no_writes("rs_no_partial");
    send_byte(8'h42, k); check_val("rs2_id_ack", 32'(k), 32'd1);
    send_byte(8'h21, k); check_val("rs2_sub_ack", 32'(k), 32'd1);
    send_byte(8'h3C, k); check_val("rs2_dat_ack", 32'(k), 32'd1);
    stop_c();
    mreg[8'h21] = 8'h3C; mptr = 8'h21;
    check_one_write(8'h21, 8'h3C);
    do_read();

    // Extra byte after the data byte is neither written nor ACKed.
    start_c();
    send_byte(8'h42, k); send_byte(8'h12, k); send_byte(8'h55, k);
    check_val("x_dat_ack", 32'(k), 32'd1);
    send_byte(8'hAA, k);
    check_val("x_extra_ack", 32'(k), 32'd0);
    stop_c();
    mreg[8'h12] = 8'h55; mptr = 8'h12;
    check_one_write(8'h12, 8'h55);
    do_read();

    // Randomized traffic against the model.
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0:       do_write(8'($urandom_range(0, 15)), 8'($urandom));
        1: begin set_ptr(8'($urandom_range(0, 15))); do_read(); end
        2:       do_read();
        default: bad_id(rand_bad_id());
      endcase
    end

    // pwdn mid data byte: bus released, no write, pointer and data retained.
    a = 8'h12;
    v = ~mreg[a];
    start_c();
    send_byte(8'h42, k); send_byte(a, k);
    for (int i = 7; i >= 4; i--) clk_bit(v[i], l, d);
    pwdn = 1'b1;
    repeat (4) @(negedge clk);
    check_val("pd_oe", 32'(oe), 32'd0);
    check_val("pd_busy", 32'(busy), 32'd0);
    for (int i = 3; i >= 0; i--) clk_bit(v[i], l, d);
    clk_bit(1'b1, l, d);
    check_val("pd_no_ack", 32'(d), 32'd0);
    stop_c();
    pwdn = 1'b0;
    repeat (8) @(negedge clk);
    mptr = a;
    check_no_writes("pd_no_wr");
    do_read();

    // Reset while the target drives read bit 0 low.
    do_write(8'h44, 8'hA4);
    start_c();
    send_byte(8'h43, k);
    for (int i = 0; i < 7; i++) clk_bit(1'b1, l, d);
    check_val("rr_bit0_drive", 32'(oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rr_oe", 32'(oe), 32'd0);
    check_val("rr_busy", 32'(busy), 32'd0);
    check_val("rr_nack", 32'(nack), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    stop_c();
    for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
    mptr = 8'h00; mnack = 0;
    check_no_writes("rr_no_wr");
    set_ptr(8'h44);
    do_read();
    set_ptr(8'h12);
    do_read();

    check_val("oe_change_scl_high", 32'(oe_hi_chg), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
